// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size encodings, FSM states and default word-address width
package mem_access_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: request/response bus from the control FSM plus the word-memory port
interface mem_access_if import mem_access_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              busy;
  logic              err;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_d;
  logic              mem_we;
  logic [31:0]       mem_spo;
  modport master (output req, wr, size, sign_ext, addr, wdata, input rdata, done, busy, err);
  modport slave (input req, wr, size, sign_ext, addr, wdata, mem_spo,
                 output rdata, done, busy, err, mem_a, mem_d, mem_we);
  modport mem (input mem_a, mem_d, mem_we, output mem_spo);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend for loads and lane merge for stores
module mem_lane_align import mem_access_pkg::*; (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_sext,
  input  logic [31:0] i_spo,
  input  logic [31:0] i_wd,
  output logic [31:0] o_ld,
  output logic [31:0] o_st
);
  logic [4:0]  w_sh;
  logic [31:0] w_sft;
  logic [31:0] w_m;
  assign w_sh  = {i_off, 3'b000};
  assign w_sft = i_spo >> w_sh;
  assign w_m   = i_size == SZ_BYTE ? 32'h0000_00ff << w_sh :
                 i_size == SZ_HALF ? 32'h0000_ffff << w_sh : '1;
  assign o_ld  = i_size == SZ_BYTE ? {{24{i_sext & w_sft[7]}}, w_sft[7:0]} :
                 i_size == SZ_HALF ? {{16{i_sext & w_sft[15]}}, w_sft[15:0]} : i_spo;
  assign o_st  = (i_spo & ~w_m) | ((i_wd << w_sh) & w_m);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store front end with RMW for sub-word stores.
// MEM_ACCESS_ALIGN_CHECK_EN: when defined, misaligned or reserved-size accesses return done+err;
// otherwise low address bits are forced to natural alignment and size 11 acts as word.
module mem_access_unit import mem_access_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_off, r_size;
  logic              r_sext, r_wr, r_err;
  logic [31:0]       r_wd, r_rdata;
  logic [1:0]        w_size, w_off;
  logic              w_err;
  logic [31:0]       w_ld, w_st;
  logic              w_unused;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign w_size = bus.size;
  assign w_off  = bus.addr[1:0];
  assign w_err  = bus.size == SZ_RSVD || (bus.size == SZ_HALF && bus.addr[0]) ||
                  (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00);
`else
  assign w_size = bus.size == SZ_RSVD ? SZ_WORD : bus.size;
  assign w_off  = w_size == SZ_WORD ? 2'b00 : w_size == SZ_HALF ? {bus.addr[1], 1'b0} : bus.addr[1:0];
  assign w_err  = 1'b0;
`endif
  assign w_unused = ^bus.addr[31:ADDR_W+2];
  mem_lane_align u_align (
    .i_size (r_size),
    .i_off  (r_off),
    .i_sext (r_sext),
    .i_spo  (bus.mem_spo),
    .i_wd   (r_wd),
    .o_ld   (w_ld),
    .o_st   (w_st)
  );
  // state register; reset drops out of WR at once so a pending write never commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next state: errors skip memory, word stores skip the read, everything else reads first
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !bus.req ? IDLE : w_err ? RESP : (!bus.wr || w_size != SZ_WORD) ? RD : WR;
      RD:      w_next = r_wr ? WR : RESP;
      WR:      w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // latch the request in IDLE, then either capture the load result or the merged store word in RD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_off   <= '0;
      r_size  <= '0;
      r_sext  <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_wd    <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && bus.req) begin
        r_idx  <= bus.addr[ADDR_W+1:2];
        r_off  <= w_off;
        r_size <= w_size;
        r_sext <= bus.sign_ext;
        r_wr   <= bus.wr;
        r_err  <= w_err;
        r_wd   <= bus.wdata;
      end
      if (r_state == RD) begin
        if (r_wr) r_wd    <= w_st;
        else      r_rdata <= w_ld;
      end
    end
  end
  assign bus.mem_a  = r_idx;
  assign bus.mem_d  = r_wd;
  assign bus.mem_we = r_state == WR;
  assign bus.rdata  = r_rdata;
  assign bus.done   = r_state == RESP;
  assign bus.busy   = r_state != IDLE;
  assign bus.err    = r_state == RESP && r_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors against a behavioural word memory
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] mem [32];
  mem_access_if #(.ADDR_W(5)) bus ();
  mem_access_unit #(.ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_spo = mem[bus.mem_a];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a] <= bus.mem_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output int nwe,
                     output logic [31:0] wa, output logic [31:0] wd, output logic e);
    bus.wr = w; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.wdata = d; bus.req = 1'b1;
    lat = 99; nwe = 0; wa = '0; wd = '0; e = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      bus.req = 1'b0;
      if (bus.mem_we) begin nwe++; wa = 32'(bus.mem_a); wd = bus.mem_d; end
      if (bus.done) begin lat = i; e = bus.err; break; end
    end
    @(posedge clk); #1;
  endtask

  int lat, nwe, nd;
  logic [31:0] wa, wd, keep;
  logic e;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    bus.req = 0; bus.wr = 0; bus.size = 0; bus.sign_ext = 0; bus.addr = 0; bus.wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_mem_a", 32'(bus.mem_a), 0);
    chk("rst_mem_d", bus.mem_d, 0);

    run(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, lat, nwe, wa, wd, e);
    chk("sw_lat", lat, 2); chk("sw_nwe", nwe, 1); chk("sw_a", wa, 2);
    chk("sw_d", wd, 32'hDEADBEEF); chk("sw_err", 32'(e), 0); chk("sw_mem", mem[2], 32'hDEADBEEF);
    run(0, 2'b10, 0, 32'h08, 0, lat, nwe, wa, wd, e);
    chk("lw_lat", lat, 2); chk("lw_nwe", nwe, 0); chk("lw_rdata", bus.rdata, 32'hDEADBEEF);

    run(1, 2'b00, 0, 32'h09, 32'h000000A5, lat, nwe, wa, wd, e);
    chk("sb_lat", lat, 3); chk("sb_nwe", nwe, 1); chk("sb_a", wa, 2);
    chk("sb_d", wd, 32'hDEADA5EF); chk("sb_mem", mem[2], 32'hDEADA5EF);
    chk("sb_mem1", mem[1], 0); chk("sb_mem3", mem[3], 0);
    chk("sb_rdata_kept", bus.rdata, 32'hDEADBEEF);

    run(0, 2'b00, 1, 32'h0B, 0, lat, nwe, wa, wd, e);
    chk("lb_s_lat", lat, 2); chk("lb_s", bus.rdata, 32'hFFFFFFDE);
    run(0, 2'b00, 0, 32'h0B, 0, lat, nwe, wa, wd, e);
    chk("lb_u", bus.rdata, 32'h000000DE);
    run(0, 2'b01, 1, 32'h0A, 0, lat, nwe, wa, wd, e);
    chk("lh_s", bus.rdata, 32'hFFFFDEAD);
    run(0, 2'b01, 0, 32'h08, 0, lat, nwe, wa, wd, e);
    chk("lh_u", bus.rdata, 32'h0000A5EF); chk("lh_nwe", nwe, 0);

    run(1, 2'b10, 0, 32'h84, 32'h12348765, lat, nwe, wa, wd, e);
    chk("wrap_a", wa, 1); chk("wrap_mem", mem[1], 32'h12348765);
    run(0, 2'b01, 0, 32'h05, 0, lat, nwe, wa, wd, e);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    chk("mis_lat", lat, 1); chk("mis_err", 32'(e), 1); chk("mis_nwe", nwe, 0);
    chk("mis_rdata", bus.rdata, 32'h0000A5EF);
    run(0, 2'b11, 0, 32'h04, 0, lat, nwe, wa, wd, e);
    chk("rsv_lat", lat, 1); chk("rsv_err", 32'(e), 1); chk("rsv_rdata", bus.rdata, 32'h0000A5EF);
    run(1, 2'b10, 0, 32'h06, 32'hCAFEF00D, lat, nwe, wa, wd, e);
    chk("mis_st_err", 32'(e), 1); chk("mis_st_nwe", nwe, 0); chk("mis_st_mem", mem[1], 32'h12348765);
`else
    chk("mis_lat", lat, 2); chk("mis_err", 32'(e), 0); chk("mis_rdata", bus.rdata, 32'h00008765);
    run(0, 2'b11, 0, 32'h06, 0, lat, nwe, wa, wd, e);
    chk("rsv_lat", lat, 2); chk("rsv_err", 32'(e), 0); chk("rsv_rdata", bus.rdata, 32'h12348765);
`endif

    keep = bus.rdata;
    bus.wr = 0; bus.size = 2'b00; bus.sign_ext = 0; bus.addr = 32'h0B; bus.req = 1'b1;
    nd = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
      if (i == 1) begin bus.size = 2'b10; bus.addr = 32'h08; chk("hold_busy1", 32'(bus.busy), 1); end
      if (i == 2) begin chk("hold_done2", 32'(bus.done), 1); chk("hold_rdata1", bus.rdata, 32'h000000DE); end
      if (i == 3) chk("hold_idle3", 32'(bus.busy), 0);
      if (i == 4) chk("hold_done4", 32'(bus.done), 0);
      if (i == 5) begin chk("hold_done5", 32'(bus.done), 1); chk("hold_rdata2", bus.rdata, 32'hDEADA5EF); end
    end
    chk("hold_ndone", nd, 2);
    bus.req = 1'b0;
    @(posedge clk); #1;

    bus.wr = 1; bus.size = 2'b10; bus.addr = 32'h10; bus.wdata = 32'h11223344; bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk("rwr_we_pre", 32'(bus.mem_we), 1);
    #2 rst = 1'b1;
    #1;
    chk("rwr_we", 32'(bus.mem_we), 0);
    chk("rwr_busy", 32'(bus.busy), 0);
    chk("rwr_done", 32'(bus.done), 0);
    chk("rwr_rdata", bus.rdata, 0);
    chk("rwr_mem_a", 32'(bus.mem_a), 0);
    chk("rwr_mem_d", bus.mem_d, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rwr_mem", mem[4], 0);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.mem_we) nd++;
    end
    chk("rwr_nodone", nd, 0);
    chk("rwr_mem_after", mem[4], 0);
    if (keep === 32'hx) n_fail++;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
